pwm_measure_multi: RTL

Parametrised multi-channel pulse-width measurement block, successor to the single-channel PWM measurer feeding the distance path. Each channel synchronises an asynchronous PWM/echo input, counts its high time in prescaled clock ticks and publishes a saturated `WIDTH`-bit result with a one-cycle valid strobe. It adds a per-channel no-signal timeout and optional 4-sample averaging. It sits between the sensor input pins and the distance consumer logic.

---
 rtl/pwm_measure_multi.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_measure_multi.sv
// -----------------------------------------------------------------------------
// pwm_measure_multi
//
// Multi-channel pulse-width measurement. Each channel synchronises an
// asynchronous PWM/echo input, counts its high time in prescaled clock ticks
// and publishes a saturated WIDTH-bit result with a one-cycle valid strobe.
// A per-channel no-signal timeout flags channels that stop pulsing.
//
// Optional feature macro: PWM_MEASURE_AVG_EN
//   When defined, each channel reports the truncated mean of its last four raw
//   measurements instead of the raw count.
//
// Parameters
//   CHANNELS        number of independent input channels (>= 1)
//   WIDTH           result / counter width in bits (>= 4)
//   DIV             clk cycles per count tick (>= 1, 1 = every cycle)
//   TIMEOUT_CYCLES  idle clk cycles without a rising edge before timeout sets
//
// Ports
//   clk       in   system clock, all state on rising edge
//   reset     in   asynchronous active-high reset
//   pwm_in    in   [CHANNELS]        asynchronous pulse inputs
//   distance  out  [CHANNELS*WIDTH]  channel i result at [i*WIDTH +: WIDTH]
//   valid     out  [CHANNELS]        one-cycle strobe, slice i updated
//   timeout   out  [CHANNELS]        level flag, channel i has gone quiet
// -----------------------------------------------------------------------------
module pwm_measure_multi #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 16,
    parameter int DIV            = 1,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       pwm_in,
    output logic [CHANNELS*WIDTH-1:0] distance,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       timeout
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0]    PRE_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0]    PRE_ONE   = PW'(1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [TW-1:0]    TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]    TMO_ONE   = TW'(1);

    typedef enum logic [1:0] {
        ARM  = 2'd0,   // waiting for a low level before accepting pulses
        IDLE = 2'd1,   // low, waiting for a rising edge
        HIGH = 2'd2    // pulse in progress, counting ticks
    } ch_state_t;

    // ------------------------------------------------------------------
    // Shared prescaler: tick is high when the counter is at 0.
    // ------------------------------------------------------------------
    logic [PW-1:0] pre_q;
    logic          tick;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_ONE;
        end
    end

    assign tick = (pre_q == '0);

    // ------------------------------------------------------------------
    // Per-channel measurement
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             s1_q, s2_q, s3_q;
        logic             rise, fall;
        ch_state_t        state_q, state_d;
        logic             cnt_start, cnt_step, do_latch, tmo_run, tmo_set;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] dist_q;
        logic [WIDTH-1:0] result;
        logic [TW-1:0]    tmo_cnt_q;
        logic             tmo_q;
        logic             valid_q;

        // Synchroniser and history flop reset high: the channel then looks
        // as if it has been high forever, so ARM only exits once a genuine
        // low level has been synchronised, and no false rise is seen when a
        // pulse is already present at reset release.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q <= 1'b1;
                s2_q <= 1'b1;
                s3_q <= 1'b1;
            end else begin
                s1_q <= pwm_in[i];
                s2_q <= s1_q;
                s3_q <= s2_q;
            end
        end

        assign rise = s2_q & ~s3_q;
        assign fall = ~s2_q & s3_q;

        // State register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ARM;
            end else begin
                state_q <= state_d;
            end
        end

        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        always_comb begin
            state_d = state_q;
            unique case (state_q)
                ARM:     if (!s2_q) state_d = IDLE;
                IDLE:    if (rise)  state_d = HIGH;
                HIGH:    if (fall)  state_d = IDLE;
                default: state_d = ARM;
            endcase
        end

        // Output decode
        always_comb begin
            cnt_start = 1'b0;
            cnt_step  = 1'b0;
            do_latch  = 1'b0;
            tmo_run   = 1'b0;
            unique case (state_q)
                ARM: begin
                    tmo_run = 1'b1;
                end
                IDLE: begin
                    tmo_run   = 1'b1;
                    cnt_start = rise;
                end
                HIGH: begin
                    cnt_step = s2_q & tick;
                    do_latch = fall;
                end
                default: begin
                    tmo_run = 1'b0;
                end
            endcase
        end

        // Timeout fires on the edge that brings the idle counter to its limit;
        // a rise in the same cycle restarts the count instead.
        assign tmo_set = tmo_run & ~rise & (tmo_cnt_q == TMO_LAST);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q     <= '0;
                dist_q    <= '0;
                valid_q   <= 1'b0;
                tmo_cnt_q <= '0;
                tmo_q     <= 1'b0;
            end else begin
                valid_q <= do_latch;

                // The rise cycle itself counts when it carries a tick.
                if (cnt_start) begin
                    cnt_q <= tick ? CNT_ONE : '0;
                end else if (cnt_step && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + CNT_ONE;
                end

                if (do_latch) begin
                    dist_q <= result;
                end

                // Idle counter parks at the limit so it cannot wrap and
                // re-trigger while the channel stays quiet.
                if (rise) begin
                    tmo_cnt_q <= '0;
                end else if (tmo_run && (tmo_cnt_q != TMO_LIMIT)) begin
                    tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
                end

                if (do_latch) begin
                    tmo_q <= 1'b0;
                end else if (tmo_set) begin
                    tmo_q <= 1'b1;
                end
            end
        end

`ifdef PWM_MEASURE_AVG_EN
        // The newest sample is cnt_q itself; only the three before it are
        // stored. While empty, all four entries take the new sample.
        logic [WIDTH-1:0] hist_q [3];
        logic             hist_empty_q;
        logic [WIDTH+1:0] sum;

        always_comb begin
            if (hist_empty_q) begin
                sum = {cnt_q, 2'b00};
            end else begin
                sum = {2'b00, cnt_q} + {2'b00, hist_q[0]}
                    + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
            end
        end

        assign result = sum[WIDTH+1:2];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hist_empty_q <= 1'b1;
            end else if (do_latch) begin
                hist_empty_q <= 1'b0;
            end else if (tmo_set) begin
                hist_empty_q <= 1'b1;
            end
        end

        // NOTE: the history array has no reset; hist_empty_q masks its
        // contents until the first sample after reset overwrites every entry.
        always_ff @(posedge clk) begin
            if (do_latch) begin
                hist_q[0] <= cnt_q;
                hist_q[1] <= hist_empty_q ? cnt_q : hist_q[0];
                hist_q[2] <= hist_empty_q ? cnt_q : hist_q[1];
            end
        end
`else
        assign result = cnt_q;
`endif

        assign distance[i*WIDTH +: WIDTH] = dist_q;
        assign valid[i]                   = valid_q;
        assign timeout[i]                 = tmo_q;
    end

endmodule
